// File: rtl/div_period_meter_if.sv
// Result port of div_period_meter: one captured divider period per valid/ready transfer.
// The meter drives through the master modport and the consumer through the slave modport.
interface div_period_meter_if #(
  parameter int CNT_W = 16
);
  logic             meas_valid;
  logic             meas_ready;
  logic [CNT_W:0]   meas_period;
  logic [CNT_W-1:0] meas_high;
  logic [CNT_W-1:0] meas_low;
  logic             duty_even;

  modport master (
    output meas_valid, meas_period, meas_high, meas_low, duty_even,
    input  meas_ready
  );

  modport slave (
    input  meas_valid, meas_period, meas_high, meas_low, duty_even,
    output meas_ready
  );
endinterface

// File: rtl/div_period_meter.sv
// Period meter for an even clock divider output: high, low and total period in clk cycles.
// Define DIV_PERIOD_METER_SYNC_EN to add a two-flop synchronizer for an asynchronous div_in.
module div_period_meter #(
  parameter int CNT_W     = 16,
  parameter int STALL_CYC = 1024
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                ena,
  input  logic                clr,
  input  logic                div_in,
  div_period_meter_if.master  meas,
  output logic                overrun,
  output logic                stall
);

  typedef enum logic [1:0] {IDLE, SYNC, HIGH, LOW} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] STALL_TH = CNT_W'(STALL_CYC);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_hi, r_lo, w_hi_nxt, w_lo_nxt;
  logic             r_s, r_s_d, w_din;
  logic             w_rise, w_fall, w_capture, w_stall_nxt;

  logic             r_valid, r_overrun, r_stall, r_duty;
  logic [CNT_W:0]   r_period;
  logic [CNT_W-1:0] r_high, r_low;

`ifdef DIV_PERIOD_METER_SYNC_EN
  logic [1:0] r_meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_meta <= '0;
    else          r_meta <= {r_meta[0], div_in};
  end

  assign w_din = r_meta[1];
`else
  assign w_din = div_in;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s   <= 1'b0;
      r_s_d <= 1'b0;
    end else begin
      r_s   <= w_din;
      r_s_d <= r_s;
    end
  end

  assign w_rise = r_s & ~r_s_d;
  assign w_fall = ~r_s & r_s_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_hi    <= '0;
      r_lo    <= '0;
      r_stall <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_stall <= w_stall_nxt;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_capture   = 1'b0;

    if (!ena) begin
      w_state_nxt = IDLE;
      w_hi_nxt    = '0;
      w_lo_nxt    = '0;
    end else if (clr) begin
      w_state_nxt = SYNC;
      w_hi_nxt    = '0;
      w_lo_nxt    = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_state_nxt = SYNC;
          w_hi_nxt    = '0;
          w_lo_nxt    = '0;
        end
        // The phase in progress when measurement starts is never trusted.
        SYNC: begin
          if (w_rise) begin
            w_state_nxt = HIGH;
            w_hi_nxt    = CNT_ONE;
            w_lo_nxt    = '0;
          end
        end
        HIGH: begin
          if (w_fall) begin
            w_state_nxt = LOW;
            w_lo_nxt    = CNT_ONE;
          end else if (r_s && (r_hi != CNT_MAX)) begin
            w_hi_nxt = r_hi + CNT_ONE;
          end
        end
        LOW: begin
          if (w_rise) begin
            w_capture   = 1'b1;
            w_state_nxt = HIGH;
            w_hi_nxt    = CNT_ONE;
            w_lo_nxt    = '0;
          end else if (!r_s && (r_lo != CNT_MAX)) begin
            w_lo_nxt = r_lo + CNT_ONE;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_hi_nxt    = '0;
          w_lo_nxt    = '0;
        end
      endcase
    end

    // Stall follows the counter that will be active after this edge.
    w_stall_nxt = ((w_state_nxt == HIGH) && (w_hi_nxt >= STALL_TH)) ||
                  ((w_state_nxt == LOW)  && (w_lo_nxt >= STALL_TH));
  end

  // NOTE: result data is reset as well, since every output must read 0 out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      r_high    <= '0;
      r_low     <= '0;
      r_period  <= '0;
      r_duty    <= 1'b0;
    end else if (clr) begin
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_capture) begin
      if (!r_valid || meas.meas_ready) begin
        r_valid  <= 1'b1;
        r_high   <= r_hi;
        r_low    <= r_lo;
        r_period <= {1'b0, r_hi} + {1'b0, r_lo};
        r_duty   <= (r_hi == r_lo);
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (r_valid && meas.meas_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign meas.meas_valid  = r_valid;
  assign meas.meas_high   = r_high;
  assign meas.meas_low    = r_low;
  assign meas.meas_period = r_period;
  assign meas.duty_even   = r_duty;
  assign overrun          = r_overrun;
  assign stall            = r_stall;

endmodule

// File: tb/tb_div_period_meter.sv
// Self-checking bench for div_period_meter: directed scenarios plus random periods
// scored against an expected-period queue built from the driven high/low run lengths.
module tb_div_period_meter;
  localparam int CNT_W     = 5;
  localparam int STALL_CYC = 16;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  typedef struct {
    int h;
    int l;
  } period_t;

  logic clk = 1'b0;
  logic reset_n, ena, clr, div_in, overrun, stall;

  div_period_meter_if #(.CNT_W(CNT_W)) meas_if ();

  div_period_meter #(.CNT_W(CNT_W), .STALL_CYC(STALL_CYC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ena     (ena),
    .clr     (clr),
    .div_in  (div_in),
    .meas    (meas_if),
    .overrun (overrun),
    .stall   (stall)
  );

  always #5 clk = ~clk;

  int      n_checks = 0;
  int      n_fail   = 0;
  period_t exp_q[$];
  bit      auto_rdy = 1'b0;
  int      vage     = 0;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  task automatic push_period(input int h, input int l);
    period_t p;
    p.h = sat(h);
    p.l = sat(l);
    exp_q.push_back(p);
  endtask

  // Consumer: random ready, but never lets a result wait more than three edges.
  task automatic consume();
    period_t p;
    if (!auto_rdy) return;
    if (meas_if.meas_valid) begin
      if (vage >= 2) meas_if.meas_ready = 1'b1;
      else           meas_if.meas_ready = 1'($urandom_range(0, 1));
      if (meas_if.meas_ready) begin
        vage = 0;
        if (exp_q.size() == 0) begin
          check("sb_unexpected_result", 32'(1), 32'(0));
        end else begin
          p = exp_q.pop_front();
          check("sb_high",   32'(meas_if.meas_high),   32'(p.h));
          check("sb_low",    32'(meas_if.meas_low),    32'(p.l));
          check("sb_period", 32'(meas_if.meas_period), 32'(p.h + p.l));
          check("sb_duty",   32'(meas_if.duty_even),   32'(p.h == p.l));
        end
      end else begin
        vage++;
      end
    end else begin
      vage = 0;
      meas_if.meas_ready = 1'($urandom_range(0, 1));
    end
  endtask

  // One clk edge with div_in = v; outputs are observed on the following falling edge.
  task automatic step(input logic v);
    div_in = v;
    @(negedge clk);
    consume();
  endtask

  task automatic drive(input logic v, input int n);
    repeat (n) step(v);
  endtask

  task automatic pulse_clr(input logic v);
    clr = 1'b1;
    step(v);
    clr = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int h, l;
    reset_n = 1'b0;
    ena     = 1'b0;
    clr     = 1'b0;
    div_in  = 1'b0;
    meas_if.meas_ready = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_valid",   32'(meas_if.meas_valid),  32'(0));
    check("rst_period",  32'(meas_if.meas_period), 32'(0));
    check("rst_high",    32'(meas_if.meas_high),   32'(0));
    check("rst_low",     32'(meas_if.meas_low),    32'(0));
    check("rst_duty",    32'(meas_if.duty_even),   32'(0));
    check("rst_overrun", 32'(overrun),             32'(0));
    check("rst_stall",   32'(stall),               32'(0));

    reset_n = 1'b1;
    drive(1'b1, 3); drive(1'b0, 3); drive(1'b1, 3);
    check("idle_valid", 32'(meas_if.meas_valid), 32'(0));
    check("idle_stall", 32'(stall),              32'(0));

    // 3 high / 5 low with an always-willing consumer; the partial high is discarded.
    auto_rdy = 1'b1;
    drive(1'b1, 3);
    ena = 1'b1;
    drive(1'b1, 2); drive(1'b0, 5);
    repeat (4) begin
      drive(1'b1, 3); drive(1'b0, 5);
      push_period(3, 5);
    end
    drive(1'b1, 6);
    check("t2_pending",  32'(exp_q.size()), 32'(0));
    check("t2_overrun",  32'(overrun),      32'(0));

    // 4/4 with no consumer: first capture latency, then overrun keeps the first result.
    auto_rdy = 1'b0;
    meas_if.meas_ready = 1'b0;
    pulse_clr(1'b0);
    drive(1'b0, 3); drive(1'b1, 4); drive(1'b0, 4);
    step(1'b1);
    check("t3_lat_edge1", 32'(meas_if.meas_valid), 32'(0));
    step(1'b1);
    check("t3_lat_edge2", 32'(meas_if.meas_valid),  32'(1));
    check("t3_high",      32'(meas_if.meas_high),   32'(4));
    check("t3_low",       32'(meas_if.meas_low),    32'(4));
    check("t3_period",    32'(meas_if.meas_period), 32'(8));
    check("t3_duty",      32'(meas_if.duty_even),   32'(1));
    check("t3_no_ovr",    32'(overrun),             32'(0));
    drive(1'b1, 2); drive(1'b0, 6); drive(1'b1, 3);
    check("t3_overrun",   32'(overrun),             32'(1));
    check("t3_valid",     32'(meas_if.meas_valid),  32'(1));
    check("t3_kept_high", 32'(meas_if.meas_high),   32'(4));
    check("t3_kept_low",  32'(meas_if.meas_low),    32'(4));

    // Long high phase: stall at 16, saturation at CNT_MAX, stall cleared by the fall.
    pulse_clr(1'b0);
    check("t4_clr_ovr",   32'(overrun),            32'(0));
    check("t4_clr_valid", 32'(meas_if.meas_valid), 32'(0));
    drive(1'b0, 3); drive(1'b1, 16);
    check("t4_stall_below", 32'(stall), 32'(0));
    step(1'b1);
    check("t4_stall_set",   32'(stall), 32'(1));
    drive(1'b1, 25);
    step(1'b0);
    check("t4_stall_hold",  32'(stall), 32'(1));
    step(1'b0);
    check("t4_stall_clear", 32'(stall), 32'(0));
    drive(1'b0, 3); drive(1'b1, 2);
    check("t4_valid",  32'(meas_if.meas_valid),  32'(1));
    check("t4_high",   32'(meas_if.meas_high),   32'(CNT_MAX));
    check("t4_low",    32'(meas_if.meas_low),    32'(5));
    check("t4_period", 32'(meas_if.meas_period), 32'(CNT_MAX + 5));
    check("t4_duty",   32'(meas_if.duty_even),   32'(0));

    // ena dropped mid-high: the interrupted period and the re-sync phase give no result.
    pulse_clr(1'b0);
    auto_rdy = 1'b1;
    drive(1'b0, 3); drive(1'b1, 4); drive(1'b0, 4);
    push_period(4, 4);
    drive(1'b1, 3);
    ena = 1'b0;
    drive(1'b1, 3);
    ena = 1'b1;
    drive(1'b1, 2); drive(1'b0, 4);
    repeat (2) begin
      drive(1'b1, 3); drive(1'b0, 5);
      push_period(3, 5);
    end
    drive(1'b1, 6);
    check("t5_pending", 32'(exp_q.size()), 32'(0));

    // clr on the capture edge wins; the meter then re-synchronises.
    auto_rdy = 1'b0;
    meas_if.meas_ready = 1'b0;
    pulse_clr(1'b0);
    drive(1'b0, 3); drive(1'b1, 4); drive(1'b0, 4);
    step(1'b1);
    pulse_clr(1'b1);
    check("t6_valid",   32'(meas_if.meas_valid), 32'(0));
    check("t6_overrun", 32'(overrun),            32'(0));
    drive(1'b1, 3); drive(1'b0, 4); drive(1'b1, 3); drive(1'b0, 5); drive(1'b1, 2);
    check("t6_resync_valid", 32'(meas_if.meas_valid), 32'(1));
    check("t6_resync_high",  32'(meas_if.meas_high),  32'(3));
    check("t6_resync_low",   32'(meas_if.meas_low),   32'(5));
    check("t6_resync_ovr",   32'(overrun),            32'(0));

    // Random periods, including phases long enough to saturate the counters.
    pulse_clr(1'b0);
    auto_rdy = 1'b1;
    drive(1'b0, 3);
    repeat (16) begin
      h = $urandom_range(2, 40);
      l = $urandom_range(2, 40);
      drive(1'b1, h); drive(1'b0, l);
      push_period(h, l);
    end
    drive(1'b1, 6);
    check("rand_pending", 32'(exp_q.size()), 32'(0));
    check("rand_overrun", 32'(overrun),      32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
